// File: rtl/regfile_scanner.sv
// Walks a regfile read port from first_reg to last_reg (wrapping) and streams each value out on valid/ready.
// Optional REGSCAN_CHECKSUM_EN appends an XOR-checksum beat (flagged by out_is_sum) after the last register.
module regfile_scanner #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH-1:0] last_reg,
    output logic [ADDR_WIDTH-1:0] ctrl_readReg,
    input  logic [DATA_WIDTH-1:0] data_readReg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
`ifdef REGSCAN_CHECKSUM_EN
    output logic                  out_is_sum,
`endif
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
`ifdef REGSCAN_CHECKSUM_EN
        SUM,
`endif
        DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic                  handshake;
    logic                  at_last;
`ifdef REGSCAN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;
`endif

    assign handshake    = out_valid && out_ready;
    assign at_last      = (addr == last_q);
    // The read port simply follows the walk address, so it holds its value outside FETCH.
    assign ctrl_readReg = addr;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: next_state = SEND;
            SEND: begin
                if (out_ready) begin
`ifdef REGSCAN_CHECKSUM_EN
                    next_state = at_last ? SUM : FETCH;
`else
                    next_state = at_last ? DONE : FETCH;
`endif
                end
            end
`ifdef REGSCAN_CHECKSUM_EN
            SUM:   if (out_ready) next_state = DONE;
`endif
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: bounds latch, walk address, captured beat and (optionally) running checksum.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            addr    <= '0;
            last_q  <= '0;
            data_q  <= '0;
            index_q <= '0;
`ifdef REGSCAN_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr   <= first_reg;
                        last_q <= last_reg;
`ifdef REGSCAN_CHECKSUM_EN
                        csum   <= '0;
`endif
                    end
                end
                FETCH: begin
                    data_q  <= data_readReg;
                    index_q <= addr;
                end
                SEND: begin
                    if (handshake) begin
                        if (!at_last) addr <= addr + 1'b1;
`ifdef REGSCAN_CHECKSUM_EN
                        csum <= csum ^ data_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_valid = (state == SEND);
        out_data  = data_q;
        out_index = index_q;
        busy      = (state != IDLE);
        done      = (state == DONE);
`ifdef REGSCAN_CHECKSUM_EN
        out_last   = 1'b0;
        out_is_sum = 1'b0;
        if (state == SUM) begin
            out_valid  = 1'b1;
            out_data   = csum;
            out_index  = '0;
            out_last   = 1'b1;
            out_is_sum = 1'b1;
        end
`else
        out_last  = (state == SEND) && (index_q == last_q);
`endif
    end

endmodule

// File: tb/tb_regfile_scanner.sv
// Directed self-checking bench for regfile_scanner; register r[i] holds i*0x11 unless overridden.
// Define REGSCAN_CHECKSUM_EN for both RTL and bench to exercise the checksum beat.
module tb_regfile_scanner;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  ctrl_readReg;
    logic [31:0] data_readReg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef REGSCAN_CHECKSUM_EN
    logic        out_is_sum;
`endif

    logic [31:0] regs [32];
    logic [31:0] csum_exp;
    int          vectors = 0;
    int          misses  = 0;

    always #5 clock = ~clock;

    assign data_readReg = regs[ctrl_readReg];

    regfile_scanner #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .start        (start),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (data_readReg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
`ifdef REGSCAN_CHECKSUM_EN
        .out_is_sum   (out_is_sum),
`endif
        .done         (done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            misses++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [4:0] f, input logic [4:0] l, input logic rdy);
        start     = s;
        first_reg = f;
        last_reg  = l;
        out_ready = rdy;
    endtask

    // With the checksum beat present, register beats never carry out_last.
    function automatic logic exp_last(input logic l);
`ifdef REGSCAN_CHECKSUM_EN
        return 1'b0;
`else
        return l;
`endif
    endfunction

    task automatic begin_scan(input logic [4:0] f, input logic [4:0] l, input logic rdy);
        applyStimulus(1'b1, f, l, rdy);
        csum_exp = 32'h0;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [4:0] idx, input logic [31:0] data, input logic last);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'h1);
        checkOutput({tag, ".index"}, {27'b0, out_index}, {27'b0, idx});
        checkOutput({tag, ".data"}, out_data, data);
        checkOutput({tag, ".last"}, {31'b0, out_last}, {31'b0, exp_last(last)});
`ifdef REGSCAN_CHECKSUM_EN
        checkOutput({tag, ".is_sum"}, {31'b0, out_is_sum}, 32'h0);
`endif
        csum_exp = csum_exp ^ data;
        if (out_ready) tick();
    endtask

    // Called right after the final register handshake; optionally pokes start during DONE.
    task automatic finish_scan(input string tag, input logic poke_start);
`ifdef REGSCAN_CHECKSUM_EN
        checkOutput({tag, ".sum_valid"}, {31'b0, out_valid}, 32'h1);
        checkOutput({tag, ".sum_data"}, out_data, csum_exp);
        checkOutput({tag, ".sum_index"}, {27'b0, out_index}, 32'h0);
        checkOutput({tag, ".sum_last"}, {31'b0, out_last}, 32'h1);
        checkOutput({tag, ".sum_flag"}, {31'b0, out_is_sum}, 32'h1);
        tick();
`endif
        checkOutput({tag, ".done"}, {31'b0, done}, 32'h1);
        checkOutput({tag, ".busy_in_done"}, {31'b0, busy}, 32'h1);
        if (poke_start) applyStimulus(1'b1, 5'd7, 5'd9, 1'b1);
        tick();
        start = 1'b0;
        checkOutput({tag, ".done_clear"}, {31'b0, done}, 32'h0);
        checkOutput({tag, ".busy_clear"}, {31'b0, busy}, 32'h0);
        tick();
        checkOutput({tag, ".stay_idle"}, {31'b0, busy}, 32'h0);
        checkOutput({tag, ".no_valid"}, {31'b0, out_valid}, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'h0);
        checkOutput({tag, ".data"}, out_data, 32'h0);
        checkOutput({tag, ".index"}, {27'b0, out_index}, 32'h0);
        checkOutput({tag, ".last"}, {31'b0, out_last}, 32'h0);
        checkOutput({tag, ".readReg"}, {27'b0, ctrl_readReg}, 32'h0);
        checkOutput({tag, ".busy"}, {31'b0, busy}, 32'h0);
        checkOutput({tag, ".done"}, {31'b0, done}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = i * 32'h11;
        csum_exp   = 32'h0;
        ctrl_reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        check_reset_outputs("reset");
        ctrl_reset = 1'b0;
        tick();

        $display("[TB] test 1: range 1..3, two-cycle cadence");
        begin_scan(5'd1, 5'd3, 1'b1);
        checkOutput("t1.busy", {31'b0, busy}, 32'h1);
        checkOutput("t1.fetch_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("t1.readReg0", {27'b0, ctrl_readReg}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] d;
            d = (k + 1) * 32'h11;
            tick();
            checkOutput("t1.valid", {31'b0, out_valid}, 32'h1);
            checkOutput("t1.index", {27'b0, out_index}, k + 1);
            checkOutput("t1.data", out_data, d);
            checkOutput("t1.last", {31'b0, out_last}, {31'b0, exp_last(k == 2)});
            csum_exp = csum_exp ^ d;
            tick();
            if (k < 2) begin
                checkOutput("t1.gap_valid", {31'b0, out_valid}, 32'h0);
                checkOutput("t1.readReg", {27'b0, ctrl_readReg}, k + 2);
            end
        end
        finish_scan("t1", 1'b0);

        $display("[TB] test 2: single register 5, start poked during DONE");
        regs[5] = 32'hDEADBEEF;
        begin_scan(5'd5, 5'd5, 1'b1);
        expect_beat("t2", 5'd5, 32'hDEADBEEF, 1'b1);
        finish_scan("t2", 1'b1);

        $display("[TB] test 3: wrap-around 30..1");
        begin_scan(5'd30, 5'd1, 1'b1);
        expect_beat("t3.r30", 5'd30, 32'h000001FE, 1'b0);
        expect_beat("t3.r31", 5'd31, 32'h0000020F, 1'b0);
        expect_beat("t3.r0", 5'd0, 32'h00000000, 1'b0);
        expect_beat("t3.r1", 5'd1, 32'h00000011, 1'b1);
        finish_scan("t3", 1'b0);

        $display("[TB] test 4: backpressure for 10 cycles");
        begin_scan(5'd1, 5'd3, 1'b0);
        expect_beat("t4.r1", 5'd1, 32'h00000011, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("t4.hold_valid", {31'b0, out_valid}, 32'h1);
            checkOutput("t4.hold_data", out_data, 32'h00000011);
            checkOutput("t4.hold_index", {27'b0, out_index}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        expect_beat("t4.r2", 5'd2, 32'h00000022, 1'b0);
        expect_beat("t4.r3", 5'd3, 32'h00000033, 1'b1);
        finish_scan("t4", 1'b0);

        $display("[TB] test 5: start while busy, then reset mid-SEND");
        begin_scan(5'd2, 5'd4, 1'b1);
        applyStimulus(1'b1, 5'd10, 5'd11, 1'b1);
        tick();
        start = 1'b0;
        expect_beat("t5.r2", 5'd2, 32'h00000022, 1'b0);
        expect_beat("t5.r3", 5'd3, 32'h00000033, 1'b0);
        expect_beat("t5.r4", 5'd4, 32'h00000044, 1'b1);
        finish_scan("t5", 1'b0);
        begin_scan(5'd1, 5'd3, 1'b0);
        tick();
        checkOutput("t5.pre_reset_valid", {31'b0, out_valid}, 32'h1);
        #2 ctrl_reset = 1'b1;
        #1 check_reset_outputs("t5.reset");
        tick();
        ctrl_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t5.no_done", {31'b0, done}, 32'h0);
            checkOutput("t5.idle", {31'b0, busy}, 32'h0);
        end

`ifdef REGSCAN_CHECKSUM_EN
        $display("[TB] test 6: checksum over r1=0xF0, r2=0x0F");
        regs[1] = 32'h000000F0;
        regs[2] = 32'h0000000F;
        out_ready = 1'b1;
        begin_scan(5'd1, 5'd2, 1'b1);
        expect_beat("t6.r1", 5'd1, 32'h000000F0, 1'b0);
        expect_beat("t6.r2", 5'd2, 32'h0000000F, 1'b0);
        checkOutput("t6.sum_literal", out_data, 32'h000000FF);
        finish_scan("t6", 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
